// File: rtl/instr_decoder_seq.sv
// instr_decoder_seq: decodes RST/LD/ST/ALU instruction words into registered datapath strobes.
// Define DEC_ILLEGAL_TRAP_EN to trap opcodes C..F and out-of-range register indices as illegal.
module instr_decoder_seq #(
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 2,
  parameter int RST_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [DATA_W+7:0]   instr,
  input  logic                mem_ack,
  output logic                soft_rst,
  output logic                load_en,
  output logic                store_en,
  output logic [NUM_REGS-1:0] reg_ce,
  output logic [NUM_REGS-1:0] reg_en,
  output logic [3:0]          instr_code,
  output logic [DATA_W-1:0]   prog_data,
  output logic                busy,
  output logic                illegal
);
`ifdef DEC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [3:0] OP_RST = 4'h0, OP_LD = 4'h1, OP_ST = 4'h2;
  typedef enum logic [1:0] {IDLE, EXEC, MEM_WAIT, RST_HOLD} state_t;
  state_t state_q, state_d;
  logic [3:0] code_q, code_d, cnt_q, cnt_d, in_op, in_idx;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NUM_REGS-1:0] ce_q, ce_d, en_q, en_d, in_oh;
  logic soft_q, soft_d, ld_q, ld_d, st_q, st_d, ill_q, ill_d, bad_q, bad_d;
  logic in_bad, accept;
  always_comb begin
    in_op = instr[DATA_W+3:DATA_W];
    in_idx = instr[DATA_W+7:DATA_W+4];
    in_oh = {{(NUM_REGS-1){1'b0}}, 1'b1} << in_idx;
    in_bad = TRAP && (in_op >= 4'hC || 32'(in_idx) >= NUM_REGS);
    // ST and RST hold the decoder until they complete; everything else can overlap the next accept
    instr_ready = !rst && (state_q == IDLE ||
                  (state_q == EXEC && (bad_q || (code_q != OP_ST && code_q != OP_RST))));
    accept = instr_valid && instr_ready;
    state_d = state_q;
    code_d = code_q;
    data_d = data_q;
    cnt_d = cnt_q;
    bad_d = bad_q;
    ill_d = ill_q;
    soft_d = 1'b0;
    ld_d = 1'b0;
    st_d = 1'b0;
    ce_d = '0;
    en_d = '0;
    if (accept) begin
      state_d = EXEC;
      code_d = in_op;
      data_d = instr[DATA_W-1:0];
      cnt_d = 4'd1;
      bad_d = in_bad;
      soft_d = !in_bad && in_op == OP_RST;
      ld_d = !in_bad && in_op == OP_LD;
      st_d = !in_bad && in_op == OP_ST;
      ce_d = (ld_d || st_d) ? in_oh : '0;
      en_d = (!in_bad && in_op >= 4'd3) ? in_oh : '0;
      ill_d = soft_d ? 1'b0 : (ill_q || in_bad);
    end else if ((state_q == EXEC && !bad_q && code_q == OP_ST) || state_q == MEM_WAIT) begin
      state_d = mem_ack ? IDLE : MEM_WAIT;
      st_d = !mem_ack;
      ce_d = mem_ack ? '0 : ce_q;
    end else if (soft_q) begin
      state_d = (cnt_q == 4'(RST_CYCLES)) ? IDLE : RST_HOLD;
      soft_d = state_d == RST_HOLD;
      cnt_d = cnt_q + 4'd1;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
      bad_q <= 1'b0;
      ill_q <= 1'b0;
      soft_q <= 1'b0;
      ld_q <= 1'b0;
      st_q <= 1'b0;
      ce_q <= '0;
      en_q <= '0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
      bad_q <= bad_d;
      ill_q <= ill_d;
      soft_q <= soft_d;
      ld_q <= ld_d;
      st_q <= st_d;
      ce_q <= ce_d;
      en_q <= en_d;
    end
  end
  assign soft_rst = soft_q;
  assign load_en = ld_q;
  assign store_en = st_q;
  assign reg_ce = ce_q;
  assign reg_en = en_q;
  assign instr_code = code_q;
  assign prog_data = data_q;
  assign busy = state_q != IDLE;
  assign illegal = ill_q;
endmodule

// File: tb/tb_instr_decoder_seq.sv
// tb_instr_decoder_seq: directed cycle table plus randomized run against a transaction-level model.
module tb_instr_decoder_seq;
  localparam int DW = 8, NR = 2, RC = 3;
`ifdef DEC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
  localparam logic [8:0] O_D = 9'b000000011, O_DI = 9'b000000001, O_L5 = 9'b000000011, O_L5I = 9'b000000001;
`else
  localparam bit TRAP = 1'b0;
  localparam logic [8:0] O_D = 9'b000001010, O_DI = 9'b000000000, O_L5 = 9'b010000010, O_L5I = 9'b000000000;
`endif
  localparam logic [8:0] O_0 = 9'b000000000, O_LD10 = 9'b010100010, O_EN01 = 9'b000000110,
                         O_EN10 = 9'b000001010, O_ST01 = 9'b001010010, O_SOFT = 9'b100000010;
  localparam int K_NONE = 0, K_LD = 1, K_ALU = 2, K_ST = 3, K_RST = 4, K_ILL = 5;
  logic clk = 1'b0;
  logic rst = 1'b1, instr_valid = 1'b0, mem_ack = 1'b0;
  logic [DW+7:0] instr = '0;
  logic instr_ready, soft_rst, load_en, store_en, busy, illegal;
  logic [NR-1:0] reg_ce, reg_en;
  logic [3:0] instr_code;
  logic [DW-1:0] prog_data;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  instr_decoder_seq #(.DATA_W(DW), .NUM_REGS(NR), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .mem_ack(mem_ack), .soft_rst(soft_rst), .load_en(load_en), .store_en(store_en),
    .reg_ce(reg_ce), .reg_en(reg_en), .instr_code(instr_code), .prog_data(prog_data),
    .busy(busy), .illegal(illegal)
  );
  typedef struct {
    logic r, v;
    logic [15:0] ins;
    logic ack, rdy;
    logic [8:0] outs;
    logic [3:0] code;
    logic [7:0] data;
  } vec_t;
  vec_t tbl[$];
  int m_kind = K_NONE, m_idx = 0, m_left = 0;
  logic [3:0] m_code = '0;
  logic [7:0] m_data = '0;
  logic m_ill = 1'b0;
  function automatic vec_t mk(logic r, logic v, logic [15:0] ins, logic ack, logic rdy,
                              logic [8:0] outs, logic [3:0] code, logic [7:0] data);
    vec_t t;
    t.r = r; t.v = v; t.ins = ins; t.ack = ack; t.rdy = rdy; t.outs = outs; t.code = code; t.data = data;
    return t;
  endfunction
  function automatic logic [8:0] outs_now();
    return {soft_rst, load_en, store_en, reg_ce, reg_en, busy, illegal};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask
  // Reference model: tracks which instruction kind currently owns the outputs
  function automatic logic m_ready(input logic r);
    return !r && (m_kind == K_NONE || m_kind == K_LD || m_kind == K_ALU || m_kind == K_ILL);
  endfunction
  task automatic m_step(input logic r, input logic v, input logic rdy, input logic [15:0] ins, input logic ack);
    int op;
    op = int'(ins[11:8]);
    if (r) begin
      m_kind = K_NONE; m_code = '0; m_data = '0; m_ill = 1'b0;
    end else if (v && rdy) begin
      m_idx = int'(ins[15:12]); m_code = ins[11:8]; m_data = ins[7:0];
      if (TRAP && (op >= 12 || m_idx >= NR)) begin
        m_kind = K_ILL; m_ill = 1'b1;
      end else if (op == 0) begin
        m_kind = K_RST; m_left = RC; m_ill = 1'b0;
      end else m_kind = (op == 1) ? K_LD : (op == 2) ? K_ST : K_ALU;
    end else if (m_kind == K_ST) m_kind = ack ? K_NONE : K_ST;
    else if (m_kind == K_RST) begin
      m_left--;
      if (m_left == 0) m_kind = K_NONE;
    end else m_kind = K_NONE;
  endtask
  function automatic logic [8:0] m_outs();
    logic [NR-1:0] oh;
    oh = (m_idx < NR) ? NR'(1 << m_idx) : '0;
    return {m_kind == K_RST, m_kind == K_LD, m_kind == K_ST,
            (m_kind == K_LD || m_kind == K_ST) ? oh : '0, (m_kind == K_ALU) ? oh : '0,
            m_kind != K_NONE, m_ill};
  endfunction
  initial begin
    logic er;
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, O_0, 4'h0, 8'h00));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, O_0, 4'h0, 8'h00));
    tbl.push_back(mk(0, 1, 16'h11A5, 0, 1, O_LD10, 4'h1, 8'hA5));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, O_0, 4'h1, 8'hA5));
    tbl.push_back(mk(0, 1, 16'h0333, 0, 1, O_EN01, 4'h3, 8'h33));
    tbl.push_back(mk(0, 1, 16'h1444, 0, 1, O_EN10, 4'h4, 8'h44));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, O_0, 4'h4, 8'h44));
    tbl.push_back(mk(0, 1, 16'h0277, 0, 1, O_ST01, 4'h2, 8'h77));
    tbl.push_back(mk(0, 1, 16'h11FF, 0, 0, O_ST01, 4'h2, 8'h77));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, O_ST01, 4'h2, 8'h77));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 0, O_0, 4'h2, 8'h77));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, O_0, 4'h2, 8'h77));
    tbl.push_back(mk(0, 1, 16'h0000, 0, 1, O_SOFT, 4'h0, 8'h00));
    tbl.push_back(mk(0, 1, 16'h1444, 0, 0, O_SOFT, 4'h0, 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, O_SOFT, 4'h0, 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, O_0, 4'h0, 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, O_0, 4'h0, 8'h00));
    tbl.push_back(mk(0, 1, 16'h0255, 0, 1, O_ST01, 4'h2, 8'h55));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, O_ST01, 4'h2, 8'h55));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, O_ST01, 4'h2, 8'h55));
    tbl.push_back(mk(1, 0, 16'h0000, 0, 0, O_0, 4'h0, 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 1, 1, O_0, 4'h0, 8'h00));
    tbl.push_back(mk(0, 1, 16'h1D3C, 0, 1, O_D, 4'hD, 8'h3C));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, O_DI, 4'hD, 8'h3C));
    tbl.push_back(mk(0, 1, 16'h5101, 0, 1, O_L5, 4'h1, 8'h01));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 1, O_L5I, 4'h1, 8'h01));
    tbl.push_back(mk(0, 1, 16'h0000, 0, 1, O_SOFT, 4'h0, 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, O_SOFT, 4'h0, 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, O_SOFT, 4'h0, 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 0, 0, O_0, 4'h0, 8'h00));
    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].r; instr_valid = tbl[i].v; instr = tbl[i].ins; mem_ack = tbl[i].ack;
      #1 chk($sformatf("row%0d ready", i), 32'(instr_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d outs", i), 32'(outs_now()), 32'(tbl[i].outs));
      chk($sformatf("row%0d code", i), 32'(instr_code), 32'(tbl[i].code));
      chk($sformatf("row%0d data", i), 32'(prog_data), 32'(tbl[i].data));
    end
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst = (c < 2) || ($urandom_range(0, 79) == 0);
      instr_valid = $urandom_range(0, 9) < 6;
      instr = {4'($urandom_range(0, 3)),
               ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15)),
               8'($urandom)};
      mem_ack = $urandom_range(0, 9) < 3;
      #1 er = m_ready(rst);
      chk($sformatf("rnd%0d ready", c), 32'(instr_ready), 32'(er));
      @(posedge clk);
      m_step(rst, instr_valid, er, instr, mem_ack);
      #1;
      chk($sformatf("rnd%0d outs", c), 32'(outs_now()), 32'(m_outs()));
      chk($sformatf("rnd%0d code", c), 32'(instr_code), 32'(m_code));
      chk($sformatf("rnd%0d data", c), 32'(prog_data), 32'(m_data));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
